// File: rtl/frame_buffer.sv
// -----------------------------------------------------------------------------
// frame_buffer
//
// Purpose:
//   Collects the 12-bit fast words produced by the byte-to-word writer into a
//   ping-pong buffer of WORDS entries per frame. It also stores the per-frame
//   slow word into a slot memory addressed by a slot counter (sAddr), which
//   this block owns and feeds back to the writer. The telemetry frame
//   generator reads completed frames through a read port with a latency of
//   one cycle.
//
// Ports:
//   clk     in   1   system clock
//   rst     in   1   asynchronous active-low reset
//   fData   in  12   fast word from the writer
//   fVal    in   1   one-cycle strobe, fData valid
//   sData   in  12   slow word from the writer
//   sVal    in   1   one-cycle strobe, sData valid
//   sAddr   out 11   current slow slot (0..SLOTS-1), fed back to the writer
//   frmRdy  out  1   a completed frame is held in the read bank
//   rdDone  in   1   one-cycle pulse, the reader releases the read bank
//   rdReq   in   1   read request
//   rdSel   in   1   0 = fast bank, 1 = slow slot memory
//   rdAddr  in  11   read address
//   rdData  out 12   read data
//   rdVal   out  1   rdData valid, one-cycle pulse
//   ovf     out  1   sticky frame-overrun flag
//
// Handshake semantics:
//   fVal, sVal, rdDone and rdReq are single-cycle strobes. There is no
//   back-pressure: each strobe is acted on in the cycle it is sampled high.
//   A read sampled at edge N returns rdData together with rdVal=1 after edge
//   N. rdVal is high for exactly one cycle per request, and back-to-back
//   requests produce one rdVal per cycle. rdData holds its last value while
//   no request is pending.
// -----------------------------------------------------------------------------
module frame_buffer #(
  parameter int          WORDS     = 16,
  parameter int          SLOTS     = 64,
  parameter logic [11:0] SYNC_WORD = 12'h800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] fData,
  input  logic        fVal,
  input  logic [11:0] sData,
  input  logic        sVal,
  output logic [10:0] sAddr,
  output logic        frmRdy,
  input  logic        rdDone,
  input  logic        rdReq,
  input  logic        rdSel,
  input  logic [10:0] rdAddr,
  output logic [11:0] rdData,
  output logic        rdVal,
  output logic        ovf
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);
  localparam logic [10:0]   LAST_SLOT = 11'(SLOTS - 1);
  // The limits are 12 bits wide so that SLOTS = 2048 still compares correctly
  // against the 11-bit read address.
  localparam logic [11:0]   WORDS_LIM = 12'(WORDS);
  localparam logic [11:0]   SLOTS_LIM = 12'(SLOTS);

  // The complete control state is grouped in a single struct so that it can
  // be observed as one value. There is no other sequencing state.
  typedef struct packed {
    logic          frmRdy;
    logic          wrBank;
    logic [CW-1:0] wrCnt;
  } ctrlState_t;

  ctrlState_t ctrlState;

  logic [11:0] memF [2][WORDS];
  logic [11:0] memS [SLOTS];

  logic        frameEnd;
  logic        swapOk;
  logic        rdBank;
  logic [11:0] rdNext;

  // A frame ends on the fVal that writes the last word of the write bank.
  assign frameEnd = fVal && (ctrlState.wrCnt == LAST_WORD);
  // The bank swap is allowed if the read bank is free, or if the reader frees
  // it in the same cycle.
  assign swapOk   = !ctrlState.frmRdy || rdDone;
  // The read bank is always the one that is not being written, so reads and
  // writes never touch the same bank.
  assign rdBank   = ~ctrlState.wrBank;

  assign frmRdy   = ctrlState.frmRdy;

  // ---------------------------------------------------------------------------
  // Control: write counter, bank toggle, frame-ready, slot counter, overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrlState <= '0;
      sAddr     <= '0;
      ovf       <= 1'b0;
    end else begin
      if (fVal) begin
        ctrlState.wrCnt <= frameEnd ? '0 : ctrlState.wrCnt + CW'(1);
      end

      if (frameEnd) begin
        sAddr <= (sAddr == LAST_SLOT) ? '0 : sAddr + 11'd1;
        if (swapOk) begin
          ctrlState.wrBank <= ~ctrlState.wrBank;
          ctrlState.frmRdy <= 1'b1;
        end else begin
          // The reader still holds the previous frame. That frame is kept
          // intact, and the next frame overwrites the write bank.
          ovf <= 1'b1;
        end
      end else if (rdDone) begin
        ctrlState.frmRdy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fast word memory (two banks)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < WORDS; w++) begin
          memF[b][w] <= '0;
        end
      end
    end else if (fVal) begin
      memF[ctrlState.wrBank][ctrlState.wrCnt] <= fData;
    end
  end

  // ---------------------------------------------------------------------------
  // Slow slot memory. Slot 0 is reserved for the sync word and is never
  // written. A write in the same cycle as a frame end uses the slot value
  // from before the increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SLOTS; s++) begin
        memS[s] <= '0;
      end
    end else if (sVal && (sAddr != '0)) begin
      memS[sAddr[SW-1:0]] <= sData;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  always_comb begin
    rdNext = '0;
    if (!rdSel) begin
      if ({1'b0, rdAddr} < WORDS_LIM) begin
        rdNext = memF[rdBank][rdAddr[CW-1:0]];
      end
    end else if (rdAddr == '0) begin
      rdNext = SYNC_WORD;
    end else if ({1'b0, rdAddr} < SLOTS_LIM) begin
      rdNext = memS[rdAddr[SW-1:0]];
    end
  end

  // The bank select is captured together with the request. A swap in the same
  // cycle therefore affects only the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdData <= '0;
      rdVal  <= 1'b0;
    end else begin
      rdVal <= rdReq;
      if (rdReq) begin
        rdData <= rdNext;
      end
    end
  end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
Downstream consumer of the byte-to-word writer stage. Collects the 12-bit fast words (fData/fVal) into a ping-pong buffer of WORDS entries per frame. Stores the per-frame slow word (sData/sVal) into a slot memory indexed by the slot counter sAddr, which this block generates and feeds back to the writer. The telemetry frame generator reads out completed frames over a 1-cycle-latency read port.

Parameters:
WORDS, 16, fast words per frame (power of 2, ≤16)
SLOTS, 64, slow-word slots before sAddr wraps (2..2048)
SYNC_WORD, 12'h800, value returned for slow slot 0 (unreachable by writer format {0,data,0})

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
fData  in  12  fast word from writer
fVal  in  1  one-cycle strobe, fData valid
sData  in  12  slow word from writer
sVal  in  1  one-cycle strobe, sData valid
sAddr  out  11  current slow slot, 0..SLOTS-1, to writer
frmRdy  out  1  a completed frame is held in the read bank
rdDone  in  1  one-cycle pulse, reader releases the read bank
rdReq  in  1  read request
rdSel  in  1  0 = fast bank, 1 = slow slot memory
rdAddr  in  11  read address
rdData  out  12  read data
rdVal  out  1  rdData valid, one-cycle pulse
ovf  out  1  sticky frame-overrun flag

Behaviour:
- Reset (async, rst=0): sAddr=0, frmRdy=0, rdData=0, rdVal=0, ovf=0. Write counter wrCnt=0, wrBank=0. All fast and slow memory words = 0. Reset mid-frame discards the partial frame.
- Fast write: on fVal, mem_f[wrBank][wrCnt] <= fData, then wrCnt++.
- Frame completion: fVal with wrCnt==WORDS-1. Always: wrCnt<=0 and sAddr <= (sAddr==SLOTS-1) ? 0 : sAddr+1.
  - frmRdy==0, or rdDone in the same cycle: wrBank toggles, frmRdy<=1.
  - frmRdy==1 and no rdDone: no toggle, frmRdy stays 1, ovf<=1 (sticky). The read bank is untouched and the next frame overwrites the write bank.
- rdDone without completion: frmRdy<=0. rdDone while frmRdy==0 is ignored.
- Slow write: on sVal, mem_s[sAddr] <= sData, using the pre-increment sAddr if completion occurs in the same cycle. sVal while sAddr==0 is ignored, so slot 0 is never written. fVal and sVal in the same cycle are both serviced.
- Read bank is always ~wrBank, so reads never collide with writes.
- Read: rdReq sampled at cycle N; rdData and rdVal=1 at cycle N+1. rdVal is low otherwise; rdData holds its last value when rdReq=0.
  - rdSel=0: mem_f[~wrBank][rdAddr] if rdAddr<WORDS, else 0.
  - rdSel=1: SYNC_WORD if rdAddr==0; mem_s[rdAddr] if 0<rdAddr<SLOTS; else 0.
- Bank select is sampled with rdReq. A swap in the same cycle takes effect for the next request.
- Reads are legal while frmRdy==0 and return current contents (0 after reset).
- Back-to-back rdReq gives one rdVal per cycle.
- No FSM beyond the wrCnt/wrBank/frmRdy state. All outputs are registered.

Test Plan:
- Reset then 16 fVal with fData=12'h008·k (k=0..15) -> frmRdy=1 after the 16th, sAddr=1, ovf=0. rdReq rdSel=0 addr 0..15 -> rdData=12'h008·k, each one cycle after request.
- After frame 1, sVal sData=12'h6AA -> stored at slot 1. Read rdSel=1 addr 1 -> 12'h6AA. Addr 0 -> 12'h800. Addr 64 -> 0.
- Two full frames, no rdDone -> ovf=1 after the 32nd fVal. Read bank still holds frame 1 values; frmRdy stays 1.
- rdDone pulsed in the same cycle as a frame's 16th fVal -> bank swaps, frmRdy remains 1, ovf=0. Reads return the new frame.
- 64 frames with rdDone after each -> sAddr runs 1..63 then wraps to 0. sVal issued at sAddr=0 -> slot 0 still reads 12'h800.
- rst low after 7 fVal mid-frame -> all outputs 0. Next 16 fVal form a complete frame with frmRdy=1 exactly on the 16th.
